sc_statemachine_player_ctrl: RTL and testbench

// - Next-generation player input controller for the shift-register game datapath.
// - Decodes start/left/right push buttons (active-low) into a clear pulse and shift-select codes.
// - Adds per-side limit inputs, a game-enable gate and parametrised hold-to-repeat (auto-shift).
// - Sits between the debounced board buttons and the player shift register; one instance per player.

---
 rtl/sc_statemachine_pkg.sv | 27 ++
 rtl/sc_statemachine_player_ctrl_timer.sv | 39 +++
 rtl/sc_statemachine_player_ctrl.sv | 156 +++++++++++++++
 tb/tb_sc_statemachine_player_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_statemachine_pkg.sv
// -----------------------------------------------------------------------------
// sc_statemachine_pkg
// Purpose : shared state codes, shift-select codes and small helpers for the
//           player input controller and its repeat timer.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package sc_statemachine_pkg;

   typedef enum logic [2:0] {
      STATE_RESET    = 3'd0,
      STATE_IDLE     = 3'd1,
      STATE_INIT     = 3'd2,
      STATE_LEFT     = 3'd3,
      STATE_RIGHT    = 3'd4,
      STATE_HOLD     = 3'd5,
      STATE_WAIT_REL = 3'd6
   } playerState_t;

   localparam logic [1:0] SHIFT_NONE  = 2'b11;
   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sc_statemachine_player_ctrl_timer.sv
// -----------------------------------------------------------------------------
// sc_repeat_timer
// Purpose : down-counter pacing hold-to-repeat shifts. Load has priority over
//           decrement; the counter saturates at zero.
// Ports   : SC_REPEAT_TIMER_CLOCK_50         in  1      clock
//           SC_REPEAT_TIMER_RESET_InLow      in  1      synchronous active-low reset
//           SC_REPEAT_TIMER_load_InHigh      in  1      load loadValue
//           SC_REPEAT_TIMER_loadValue_In     in  CNT_W  reload value
//           SC_REPEAT_TIMER_decrement_InHigh in  1      count down one step
//           SC_REPEAT_TIMER_expired_Out      out 1      last cycle of the interval
// -----------------------------------------------------------------------------
module sc_repeat_timer #(
   parameter int CNT_W = 4
) (
   input  logic             SC_REPEAT_TIMER_CLOCK_50,
   input  logic             SC_REPEAT_TIMER_RESET_InLow,
   input  logic             SC_REPEAT_TIMER_load_InHigh,
   input  logic [CNT_W-1:0] SC_REPEAT_TIMER_loadValue_In,
   input  logic             SC_REPEAT_TIMER_decrement_InHigh,
   output logic             SC_REPEAT_TIMER_expired_Out
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge SC_REPEAT_TIMER_CLOCK_50) begin
      if (!SC_REPEAT_TIMER_RESET_InLow) begin
         count <= '0;
      end else if (SC_REPEAT_TIMER_load_InHigh) begin
         count <= SC_REPEAT_TIMER_loadValue_In;
      end else if (SC_REPEAT_TIMER_decrement_InHigh && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // A load of N followed by N-1 decrements lands on 1: the interval is
   // exactly N cycles from the load edge to the edge that acts on expiry.
   assign SC_REPEAT_TIMER_expired_Out = (count == CNT_W'(1));

endmodule

// File: rtl/sc_statemachine_player_ctrl.sv
// -----------------------------------------------------------------------------
// sc_statemachine_player_ctrl
// Purpose : decodes active-low start/left/right buttons into a one-cycle clear
//           pulse and shift-select codes for one player's shift register, with
//           edge limits, a game-enable gate and optional hold-to-repeat.
// Ports   : SC_STATEMACHINE_PLAYER_CTRL_CLOCK_50           in  1  clock
//           SC_STATEMACHINE_PLAYER_CTRL_RESET_InLow        in  1  sync active-low reset
//           SC_STATEMACHINE_PLAYER_CTRL_startButton_InLow  in  1  start/restart
//           SC_STATEMACHINE_PLAYER_CTRL_leftButton_InLow   in  1  move left
//           SC_STATEMACHINE_PLAYER_CTRL_rightButton_InLow  in  1  move right
//           SC_STATEMACHINE_PLAYER_CTRL_leftLimit_InLow    in  1  0 = at left edge
//           SC_STATEMACHINE_PLAYER_CTRL_rightLimit_InLow   in  1  0 = at right edge
//           SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh      in  1  moves accepted
//           SC_STATEMACHINE_PLAYER_CTRL_clear_OutLow       out 1  clear pulse
//           SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out out 2  11 hold/01 L/10 R
//           SC_STATEMACHINE_PLAYER_CTRL_state_Out          out 3  state code
//
// state    | meaning
// ---------+------------------------------------------------------------
// RESET    | just out of reset, outputs idle
// IDLE     | waiting for start or a move request
// INIT     | clear pulse to the datapath
// LEFT     | one left shift pulse
// RIGHT    | one right shift pulse
// HOLD     | button held, timing the next repeat
// WAIT_REL | waiting for every button to be released
// -----------------------------------------------------------------------------
module sc_statemachine_player_ctrl
   import sc_statemachine_pkg::*;
#(
   parameter bit AUTOREPEAT    = 1'b1,
   parameter int REPEAT_DELAY  = 12,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_CLOCK_50,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_RESET_InLow,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_startButton_InLow,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_leftButton_InLow,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_rightButton_InLow,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_leftLimit_InLow,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_rightLimit_InLow,
   input  logic       SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh,
   output logic       SC_STATEMACHINE_PLAYER_CTRL_clear_OutLow,
   output logic [1:0] SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out,
   output logic [2:0] SC_STATEMACHINE_PLAYER_CTRL_state_Out
);

   localparam int CNT_W = $clog2(maxInt(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD);

   playerState_t     stateReg;
   playerState_t     stateNext;
   logic             holdLeft;
   logic             startPressed;
   logic             leftPressed;
   logic             rightPressed;
   logic             heldPressed;
   logic             otherPressed;
   logic             holdLimitFree;
   logic             timerLoad;
   logic             timerDecrement;
   logic             timerExpired;
   logic [CNT_W-1:0] timerLoadValue;

   assign startPressed = ~SC_STATEMACHINE_PLAYER_CTRL_startButton_InLow;
   assign leftPressed  = ~SC_STATEMACHINE_PLAYER_CTRL_leftButton_InLow;
   assign rightPressed = ~SC_STATEMACHINE_PLAYER_CTRL_rightButton_InLow;

   // holdLeft remembers which side is being repeated while in HOLD.
   assign heldPressed   = holdLeft ? leftPressed  : rightPressed;
   assign otherPressed  = holdLeft ? rightPressed : leftPressed;
   assign holdLimitFree = holdLeft ? SC_STATEMACHINE_PLAYER_CTRL_leftLimit_InLow
                                   : SC_STATEMACHINE_PLAYER_CTRL_rightLimit_InLow;

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         STATE_RESET: stateNext = STATE_IDLE;
         STATE_IDLE: begin
            if (startPressed) begin
               stateNext = STATE_INIT;
            end else if (SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh && leftPressed &&
                         !rightPressed && SC_STATEMACHINE_PLAYER_CTRL_leftLimit_InLow) begin
               stateNext = STATE_LEFT;
            end else if (SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh && rightPressed &&
                         !leftPressed && SC_STATEMACHINE_PLAYER_CTRL_rightLimit_InLow) begin
               stateNext = STATE_RIGHT;
            end
         end
         STATE_INIT:  stateNext = STATE_WAIT_REL;
         STATE_LEFT:  stateNext = (AUTOREPEAT && leftPressed)  ? STATE_HOLD : STATE_WAIT_REL;
         STATE_RIGHT: stateNext = (AUTOREPEAT && rightPressed) ? STATE_HOLD : STATE_WAIT_REL;
         STATE_HOLD: begin
            if (!heldPressed || otherPressed || startPressed ||
                !SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh) begin
               stateNext = STATE_WAIT_REL;
            end else if (timerExpired && holdLimitFree) begin
               stateNext = holdLeft ? STATE_LEFT : STATE_RIGHT;
            end
         end
         STATE_WAIT_REL: begin
            if (!startPressed && !leftPressed && !rightPressed) begin
               stateNext = STATE_IDLE;
            end
         end
         default: stateNext = STATE_IDLE;
      endcase
   end

   // The timer runs from the pulse cycle onwards so that the pulse-to-pulse
   // spacing equals the load value. An expiry while blocked by the limit
   // reloads the period, keeping later repeats on the period grid.
   assign timerLoad      = (stateNext == STATE_LEFT) || (stateNext == STATE_RIGHT) ||
                           ((stateReg == STATE_HOLD) && timerExpired);
   assign timerLoadValue = (stateReg == STATE_HOLD) ? PERIOD_LOAD : DELAY_LOAD;
   assign timerDecrement = (stateReg == STATE_LEFT) || (stateReg == STATE_RIGHT) ||
                           (stateReg == STATE_HOLD);

   sc_repeat_timer #(
      .CNT_W (CNT_W)
   ) u_repeatTimer (
      .SC_REPEAT_TIMER_CLOCK_50         (SC_STATEMACHINE_PLAYER_CTRL_CLOCK_50),
      .SC_REPEAT_TIMER_RESET_InLow      (SC_STATEMACHINE_PLAYER_CTRL_RESET_InLow),
      .SC_REPEAT_TIMER_load_InHigh      (timerLoad),
      .SC_REPEAT_TIMER_loadValue_In     (timerLoadValue),
      .SC_REPEAT_TIMER_decrement_InHigh (timerDecrement),
      .SC_REPEAT_TIMER_expired_Out      (timerExpired)
   );

   // Outputs are registered from the next-state decode, so they always match
   // the state register one-for-one.
   always_ff @(posedge SC_STATEMACHINE_PLAYER_CTRL_CLOCK_50) begin
      if (!SC_STATEMACHINE_PLAYER_CTRL_RESET_InLow) begin
         stateReg                                       <= STATE_RESET;
         holdLeft                                       <= 1'b0;
         SC_STATEMACHINE_PLAYER_CTRL_clear_OutLow       <= 1'b1;
         SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out <= SHIFT_NONE;
      end else begin
         stateReg                                 <= stateNext;
         SC_STATEMACHINE_PLAYER_CTRL_clear_OutLow <= (stateNext != STATE_INIT);
         if (stateNext == STATE_LEFT) begin
            holdLeft                                       <= 1'b1;
            SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out <= SHIFT_LEFT;
         end else if (stateNext == STATE_RIGHT) begin
            holdLeft                                       <= 1'b0;
            SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out <= SHIFT_RIGHT;
         end else begin
            SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out <= SHIFT_NONE;
         end
      end
   end

   assign SC_STATEMACHINE_PLAYER_CTRL_state_Out = stateReg;

endmodule

// File: tb/tb_sc_statemachine_player_ctrl.sv
module tb_sc_statemachine_player_ctrl;

   localparam int D = 4;
   localparam int P = 2;

   localparam int S_RESET = 0, S_IDLE = 1, S_INIT = 2, S_LEFT = 3,
                  S_RIGHT = 4, S_HOLD = 5, S_WAIT = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstL, startL, leftL, rightL, leftLimL, rightLimL, enH;
   logic       clr0, clr1;
   logic [1:0] sh0, sh1;
   logic [2:0] st0, st1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state per instance: [0] autorepeat on, [1] autorepeat off
   int mSt[2];
   int mDir[2];   // 0 = left, 1 = right
   int mNext[2];  // absolute edge number of the next repeat opportunity

   sc_statemachine_player_ctrl #(
      .AUTOREPEAT (1'b1), .REPEAT_DELAY (D), .REPEAT_PERIOD (P)
   ) dutRepeat (
      .SC_STATEMACHINE_PLAYER_CTRL_CLOCK_50           (clk),
      .SC_STATEMACHINE_PLAYER_CTRL_RESET_InLow        (rstL),
      .SC_STATEMACHINE_PLAYER_CTRL_startButton_InLow  (startL),
      .SC_STATEMACHINE_PLAYER_CTRL_leftButton_InLow   (leftL),
      .SC_STATEMACHINE_PLAYER_CTRL_rightButton_InLow  (rightL),
      .SC_STATEMACHINE_PLAYER_CTRL_leftLimit_InLow    (leftLimL),
      .SC_STATEMACHINE_PLAYER_CTRL_rightLimit_InLow   (rightLimL),
      .SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh      (enH),
      .SC_STATEMACHINE_PLAYER_CTRL_clear_OutLow       (clr0),
      .SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out (sh0),
      .SC_STATEMACHINE_PLAYER_CTRL_state_Out          (st0)
   );

   sc_statemachine_player_ctrl #(
      .AUTOREPEAT (1'b0), .REPEAT_DELAY (D), .REPEAT_PERIOD (P)
   ) dutSingle (
      .SC_STATEMACHINE_PLAYER_CTRL_CLOCK_50           (clk),
      .SC_STATEMACHINE_PLAYER_CTRL_RESET_InLow        (rstL),
      .SC_STATEMACHINE_PLAYER_CTRL_startButton_InLow  (startL),
      .SC_STATEMACHINE_PLAYER_CTRL_leftButton_InLow   (leftL),
      .SC_STATEMACHINE_PLAYER_CTRL_rightButton_InLow  (rightL),
      .SC_STATEMACHINE_PLAYER_CTRL_leftLimit_InLow    (leftLimL),
      .SC_STATEMACHINE_PLAYER_CTRL_rightLimit_InLow   (rightLimL),
      .SC_STATEMACHINE_PLAYER_CTRL_enable_InHigh      (enH),
      .SC_STATEMACHINE_PLAYER_CTRL_clear_OutLow       (clr1),
      .SC_STATEMACHINE_PLAYER_CTRL_shiftselection_Out (sh1),
      .SC_STATEMACHINE_PLAYER_CTRL_state_Out          (st1)
   );

   // Reference behaviour: one decision per clock edge using the button rules;
   // repeat timing is tracked as an absolute edge number, not a counter.
   task automatic modelStep(input int k, input bit ar);
      bit sP, lP, rP, held, other, free;
      sP    = !startL;
      lP    = !leftL;
      rP    = !rightL;
      held  = (mDir[k] == 0) ? lP : rP;
      other = (mDir[k] == 0) ? rP : lP;
      free  = (mDir[k] == 0) ? leftLimL : rightLimL;
      if (!rstL) begin
         mSt[k] = S_RESET;
      end else begin
         case (mSt[k])
            S_RESET: mSt[k] = S_IDLE;
            S_IDLE: begin
               if (sP) mSt[k] = S_INIT;
               else if (enH && lP && !rP && leftLimL) begin
                  mSt[k] = S_LEFT; mDir[k] = 0; mNext[k] = cyc + D;
               end else if (enH && rP && !lP && rightLimL) begin
                  mSt[k] = S_RIGHT; mDir[k] = 1; mNext[k] = cyc + D;
               end
            end
            S_INIT: mSt[k] = S_WAIT;
            S_LEFT, S_RIGHT: mSt[k] = (ar && held) ? S_HOLD : S_WAIT;
            S_HOLD: begin
               if (!held || other || sP || !enH) mSt[k] = S_WAIT;
               else if (cyc == mNext[k]) begin
                  mNext[k] = cyc + P;
                  if (free) mSt[k] = (mDir[k] == 0) ? S_LEFT : S_RIGHT;
               end
            end
            S_WAIT: if (!sP && !lP && !rP) mSt[k] = S_IDLE;
            default: mSt[k] = S_IDLE;
         endcase
      end
   endtask

   function automatic logic [5:0] expVec(input int s);
      logic [2:0] code;
      logic [1:0] shv;
      code = 3'(s);
      shv  = (s == S_LEFT) ? 2'b01 : (s == S_RIGHT) ? 2'b10 : 2'b11;
      return {code, (s != S_INIT), shv};
   endfunction

   task automatic checkOut(input int k);
      logic [5:0] obs, exp;
      obs = (k == 0) ? {st0, clr0, sh0} : {st1, clr1, sh1};
      exp = expVec(mSt[k]);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL outputs_dut%0d edge=%0d observed=%h expected=%h", k, cyc, obs, exp);
      end
   endtask

   task automatic checkVal(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      modelStep(0, 1'b1);
      modelStep(1, 1'b0);
      @(negedge clk);
      checkOut(0);
      checkOut(1);
   endtask

   initial begin : stim
      int cnt;
      int mask;
      mSt[0] = S_RESET; mSt[1] = S_RESET;
      mDir[0] = 0; mDir[1] = 0; mNext[0] = 0; mNext[1] = 0;
      rstL = 1'b0; startL = 1'b1; leftL = 1'b1; rightL = 1'b1;
      leftLimL = 1'b1; rightLimL = 1'b1; enH = 1'b1;

      // reset held three cycles
      repeat (3) tick();
      checkVal("reset_state", int'(st0), S_RESET);
      rstL = 1'b1;
      tick();
      checkVal("reset_to_idle", int'(st0), S_IDLE);
      tick();

      // start held five cycles: one clear pulse
      startL = 1'b0; cnt = 0;
      repeat (5) begin tick(); if (!clr0) cnt++; end
      checkVal("start_one_clear", cnt, 1);
      checkVal("start_wait_rel", int'(st0), S_WAIT);
      startL = 1'b1;
      tick();
      checkVal("start_back_idle", int'(st0), S_IDLE);

      // left held twelve cycles: pulses at relative 0,4,6,8,10
      leftL = 1'b0; mask = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (sh0 == 2'b01) mask |= (1 << i);
      end
      checkVal("left_repeat_mask", mask, 32'h551);
      leftL = 1'b1;
      repeat (2) tick();
      checkVal("left_release_idle", int'(st0), S_IDLE);

      // without autorepeat: single right pulse for a long hold
      rightL = 1'b0; cnt = 0;
      repeat (10) begin tick(); if (sh1 == 2'b10) cnt++; end
      checkVal("single_shift_count", cnt, 1);
      rightL = 1'b1;
      repeat (2) tick();

      // right limit active: press ignored
      rightLimL = 1'b0; rightL = 1'b0; cnt = 0;
      repeat (3) begin tick(); if (sh0 != 2'b11) cnt++; end
      checkVal("limit_blocks_press", cnt, 0);
      checkVal("limit_stays_idle", int'(st0), S_IDLE);
      rightL = 1'b1; rightLimL = 1'b1;
      tick();

      // held right, limit asserts after second repeat, then frees again
      rightL = 1'b0;
      repeat (7) tick();
      rightLimL = 1'b0; cnt = 0;
      repeat (6) begin tick(); if (sh0 != 2'b11) cnt++; end
      checkVal("limit_stops_repeat", cnt, 0);
      checkVal("limit_keeps_hold", int'(st0), S_HOLD);
      rightLimL = 1'b1; cnt = 0;
      repeat (4) begin tick(); if (sh0 == 2'b10) cnt++; end
      checkVal("limit_resume", cnt, 2);
      rightL = 1'b1;
      repeat (2) tick();

      // both directions together: ignored
      leftL = 1'b0; rightL = 1'b0; cnt = 0;
      repeat (3) begin tick(); if (sh0 != 2'b11 || sh1 != 2'b11) cnt++; end
      checkVal("both_ignored", cnt, 0);
      leftL = 1'b1; rightL = 1'b1;
      tick();

      // reset during HOLD
      leftL = 1'b0;
      repeat (3) tick();
      checkVal("hold_before_reset", int'(st0), S_HOLD);
      rstL = 1'b0;
      tick();
      checkVal("reset_in_hold_state", int'(st0), S_RESET);
      checkVal("reset_in_hold_shift", int'(sh0), 3);
      rstL = 1'b1; leftL = 1'b1;
      repeat (2) tick();

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rstL = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 9) == 0) leftL = ~leftL;
         if ($urandom_range(0, 9) == 0) rightL = ~rightL;
         if (startL) startL = ($urandom_range(0, 29) != 0);
         else if ($urandom_range(0, 2) == 0) startL = 1'b1;
         if ($urandom_range(0, 9) == 0) leftLimL = ~leftLimL;
         if ($urandom_range(0, 9) == 0) rightLimL = ~rightLimL;
         enH = ($urandom_range(0, 19) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
